// File: rtl/msb_index_stream_pkg.sv
// msb_index_stream_pkg: shared state encoding and width helper for the
// set-bit index streamer.
//   state_t   IDLE = no word held, SCAN = residual word (or zero beat) pending
//   idx_width index width for an N-bit word, never below 1
package msb_index_stream_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/msb_index_stream_if.sv
// msb_index_stream_if: word-in / beat-out handshake bundle.
//   in_valid/in_ready/in_data             word accepted on valid & ready
//   out_valid/out_ready                   beat accepted on valid & ready
//   out_index/out_mask/out_last/out_zero  beat payload
//   busy                                  a word is being scanned
// slave = the streamer, master = whoever feeds words and takes beats.
interface msb_index_stream_if
  import msb_index_stream_pkg::*;
#(
  parameter int unsigned N = 32
);
  localparam int unsigned IDXW = idx_width(N);

  logic            in_valid;
  logic            in_ready;
  logic [N-1:0]    in_data;
  logic            out_valid;
  logic            out_ready;
  logic [IDXW-1:0] out_index;
  logic [N-1:0]    out_mask;
  logic            out_last;
  logic            out_zero;
  logic            busy;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_index, out_mask, out_last, out_zero, busy
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_index, out_mask, out_last, out_zero, busy
  );
endinterface

// File: rtl/msb_index_stream_onehot_to_index.sv
// msb_index_stream_onehot_to_index: combinational one-hot to binary encoder.
//   onehot  in   N     one-hot (or all-zero) vector
//   index   out  IDXW  position of the set bit, 0 for an all-zero vector
// Each index bit is the OR of every onehot bit whose position has that bit set.
module msb_index_stream_onehot_to_index
  import msb_index_stream_pkg::*;
#(
  parameter int unsigned N = 32
) (
  input  logic [N-1:0]              onehot,
  output logic [idx_width(N)-1:0]   index
);
  localparam int unsigned IDXW = idx_width(N);

  // OR-tree per index bit
  always_comb begin
    index = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (onehot[i]) begin
        index = index | IDXW'(i);
      end
    end
  end
endmodule

// File: rtl/msb_index_stream.sv
// msb_index_stream: accepts an N-bit word and streams the index of every set
// bit, MSB first, one beat per out handshake. An all-zero word yields a
// single dummy beat flagged out_zero.
//   clk   in  rising-edge clock
//   rst   in  synchronous, active-high reset
//   bus   slave modport of msb_index_stream_if (word in, beats out, busy)
// All beat fields and busy are registers; in_ready is combinational so a new
// word can load on the same edge the last beat of the previous word leaves.
module msb_index_stream
  import msb_index_stream_pkg::*;
#(
  parameter int unsigned N = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  msb_index_stream_if.slave    bus
);
  localparam int unsigned IDXW = idx_width(N);

  state_t          state_q, state_d;
  logic [N-1:0]    residual_q, residual_d;
  logic            out_valid_q, out_valid_d;
  logic [IDXW-1:0] out_index_q, out_index_d;
  logic [N-1:0]    out_mask_q, out_mask_d;
  logic            out_last_q, out_last_d;
  logic            out_zero_q, out_zero_d;
  logic            busy_q, busy_d;

  logic            beat_done_c;
  logic            in_ready_c;
  logic            load_c;
  logic [N-1:0]    scan_src_c;
  logic [N-1:0]    next_mask_c;
  logic [IDXW-1:0] next_index_c;

  // Highest set bit of w: clear every bit below the top of the OR-smear.
  function automatic logic [N-1:0] isolate_msb(input logic [N-1:0] w);
    logic [N-1:0] smear;
    smear[N-1] = w[N-1];
    for (int i = int'(N) - 2; i >= 0; i--) begin
      smear[i] = w[i] | smear[i+1];
    end
    return w & ~(smear >> 1);
  endfunction

  assign beat_done_c = out_valid_q & bus.out_ready;
  assign in_ready_c  = (state_q == IDLE) | (beat_done_c & out_last_q);
  assign load_c      = bus.in_valid & in_ready_c;

  // Word whose MSB becomes the next beat: fresh word on load, else leftover bits.
  assign scan_src_c  = load_c ? bus.in_data : (residual_q & ~out_mask_q);
  assign next_mask_c = isolate_msb(scan_src_c);

  msb_index_stream_onehot_to_index #(.N(N)) u_enc (
    .onehot (next_mask_c),
    .index  (next_index_c)
  );

  // Next-state and next-beat logic
  always_comb begin
    state_d     = state_q;
    residual_d  = residual_q;
    out_valid_d = out_valid_q;
    out_index_d = out_index_q;
    out_mask_d  = out_mask_q;
    out_last_d  = out_last_q;
    out_zero_d  = out_zero_q;

    if (load_c) begin
      state_d     = SCAN;
      residual_d  = bus.in_data;
      out_valid_d = 1'b1;
      out_index_d = next_index_c;
      out_mask_d  = next_mask_c;
      out_last_d  = ((scan_src_c & ~next_mask_c) == '0);
      out_zero_d  = (bus.in_data == '0);
    end else if (beat_done_c) begin
      if (out_last_q) begin
        state_d     = IDLE;
        residual_d  = '0;
        out_valid_d = 1'b0;
        out_index_d = '0;
        out_mask_d  = '0;
        out_last_d  = 1'b0;
        out_zero_d  = 1'b0;
      end else begin
        residual_d  = scan_src_c;
        out_index_d = next_index_c;
        out_mask_d  = next_mask_c;
        out_last_d  = ((scan_src_c & ~next_mask_c) == '0);
        out_zero_d  = 1'b0;
      end
    end

    busy_d = (state_d == SCAN);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      residual_q  <= '0;
      out_valid_q <= 1'b0;
      out_index_q <= '0;
      out_mask_q  <= '0;
      out_last_q  <= 1'b0;
      out_zero_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      residual_q  <= residual_d;
      out_valid_q <= out_valid_d;
      out_index_q <= out_index_d;
      out_mask_q  <= out_mask_d;
      out_last_q  <= out_last_d;
      out_zero_q  <= out_zero_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_q;
  assign bus.out_index = out_index_q;
  assign bus.out_mask  = out_mask_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_zero  = out_zero_q;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_msb_index_stream.sv
// tb_msb_index_stream: self-checking bench for msb_index_stream at N=8.
// Directed scenarios check fixed expectations; the random scenario checks
// every cycle against a queue of expected beats built from each accepted word.
module tb_msb_index_stream;
  localparam int unsigned N  = 8;
  localparam int          NW = 5000;

  typedef struct packed {
    logic [2:0] idx;
    logic [7:0] mask;
    logic       last;
    logic       zero;
  } beat_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  msb_index_stream_if #(.N(N)) bus ();

  msb_index_stream #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  logic       o_valid, o_last, o_zero, o_busy, o_in_ready;
  logic [2:0] o_index;
  logic [7:0] o_mask;

  beat_t mq[$];

  // One clock: drive inputs at the falling edge, sample outputs 1 ns later.
  task automatic cyc(input logic r, input logic iv, input logic [7:0] d, input logic ordy);
    @(negedge clk);
    rst           = r;
    bus.in_valid  = iv;
    bus.in_data   = d;
    bus.out_ready = ordy;
    #1;
    o_valid    = bus.out_valid;
    o_index    = bus.out_index;
    o_mask     = bus.out_mask;
    o_last     = bus.out_last;
    o_zero     = bus.out_zero;
    o_busy     = bus.busy;
    o_in_ready = bus.in_ready;
  endtask

  // Reference: set bits from MSB down, last flag on the lowest; zero word -> one dummy beat.
  function automatic void push_word(input logic [7:0] w);
    beat_t b;
    int    lo;
    if (w == 8'h00) begin
      b.idx = 3'd0; b.mask = 8'h00; b.last = 1'b1; b.zero = 1'b1;
      mq.push_back(b);
    end else begin
      lo = 0;
      for (int i = 7; i >= 0; i--) if (w[i]) lo = i;
      for (int i = 7; i >= 0; i--) begin
        if (w[i]) begin
          b.idx  = 3'(i);
          b.mask = 8'(1) << i;
          b.last = (i == lo);
          b.zero = 1'b0;
          mq.push_back(b);
        end
      end
    end
  endfunction

  task automatic test_reset();
    cyc(1'b1, 1'b1, 8'hFF, 1'b1);
    cyc(1'b1, 1'b0, 8'h00, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 1'b0);
    checks++;
    if ({o_valid, o_index, o_mask, o_last, o_zero, o_busy} !== 15'd0) begin
      errors++;
      $display("FAIL reset_outputs got v=%b i=%0d m=%h l=%b z=%b b=%b want all 0",
               o_valid, o_index, o_mask, o_last, o_zero, o_busy);
    end
    checks++;
    if (o_in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready got %b want 1", o_in_ready);
    end
  endtask

  task automatic test_pattern();
    logic [2:0] exp_idx  [4];
    logic [7:0] exp_mask [4];
    exp_idx  = '{3'd7, 3'd5, 3'd2, 3'd1};
    exp_mask = '{8'h80, 8'h20, 8'h04, 8'h02};
    cyc(1'b0, 1'b1, 8'hA6, 1'b1);
    checks++;
    if ({o_valid, o_in_ready} !== 2'b01) begin
      errors++; $display("FAIL pattern_idle got v=%b rdy=%b want v=0 rdy=1", o_valid, o_in_ready);
    end
    for (int k = 0; k < 4; k++) begin
      cyc(1'b0, 1'b0, 8'h00, 1'b1);
      checks++;
      if ({o_valid, o_index, o_mask, o_last, o_zero, o_busy} !==
          {1'b1, exp_idx[k], exp_mask[k], (k == 3), 1'b0, 1'b1}) begin
        errors++;
        $display("FAIL pattern_beat%0d got v=%b i=%0d m=%h l=%b z=%b b=%b want i=%0d m=%h l=%b",
                 k, o_valid, o_index, o_mask, o_last, o_zero, o_busy, exp_idx[k], exp_mask[k], (k == 3));
      end
    end
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    checks++;
    if ({o_valid, o_busy} !== 2'b00) begin
      errors++; $display("FAIL pattern_end got v=%b b=%b want 0 0", o_valid, o_busy);
    end
  endtask

  task automatic test_zero();
    cyc(1'b0, 1'b1, 8'h00, 1'b1);
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    checks++;
    if ({o_valid, o_zero, o_last, o_mask, o_index} !== {1'b1, 1'b1, 1'b1, 8'h00, 3'd0}) begin
      errors++;
      $display("FAIL zero_beat got v=%b z=%b l=%b m=%h i=%0d want 1 1 1 00 0",
               o_valid, o_zero, o_last, o_mask, o_index);
    end
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    checks++;
    if (o_valid !== 1'b0) begin
      errors++; $display("FAIL zero_single got v=%b want 0", o_valid);
    end
  endtask

  task automatic test_full_stall();
    int   expi;
    int   beats;
    logic done;
    logic ordy;
    expi = 7; beats = 0; done = 1'b0;
    cyc(1'b0, 1'b1, 8'hFF, 1'b0);
    for (int c = 0; c < 40 && !done; c++) begin
      ordy = c[0];
      cyc(1'b0, 1'b0, 8'h00, ordy);
      checks++;
      if ({o_valid, o_index, o_mask, o_last, o_zero} !==
          {1'b1, 3'(expi), 8'(1) << expi, (expi == 0), 1'b0}) begin
        errors++;
        $display("FAIL full_beat got v=%b i=%0d m=%h l=%b z=%b want i=%0d l=%b",
                 o_valid, o_index, o_mask, o_last, o_zero, expi, (expi == 0));
      end
      if (ordy) begin
        beats++;
        if (expi == 0) done = 1'b1;
        else expi--;
      end
    end
    checks++;
    if (beats !== 8) begin
      errors++; $display("FAIL full_count got %0d want 8", beats);
    end
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    checks++;
    if (o_valid !== 1'b0) begin
      errors++; $display("FAIL full_end got v=%b want 0", o_valid);
    end
  endtask

  task automatic test_back_to_back();
    cyc(1'b0, 1'b1, 8'h01, 1'b1);
    cyc(1'b0, 1'b1, 8'h80, 1'b1);
    checks++;
    if ({o_valid, o_index, o_last, o_in_ready} !== {1'b1, 3'd0, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL b2b_first got v=%b i=%0d l=%b rdy=%b want 1 0 1 1",
               o_valid, o_index, o_last, o_in_ready);
    end
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    checks++;
    if ({o_valid, o_index, o_mask, o_last} !== {1'b1, 3'd7, 8'h80, 1'b1}) begin
      errors++;
      $display("FAIL b2b_second got v=%b i=%0d m=%h l=%b want 1 7 80 1",
               o_valid, o_index, o_mask, o_last);
    end
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    checks++;
    if (o_valid !== 1'b0) begin
      errors++; $display("FAIL b2b_end got v=%b want 0", o_valid);
    end
  endtask

  task automatic test_reset_midscan();
    cyc(1'b0, 1'b1, 8'hF0, 1'b1);
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    cyc(1'b1, 1'b0, 8'h00, 1'b1);
    checks++;
    if ({o_valid, o_index} !== {1'b1, 3'd6}) begin
      errors++; $display("FAIL midrst_beat2 got v=%b i=%0d want 1 6", o_valid, o_index);
    end
    cyc(1'b0, 1'b1, 8'h08, 1'b1);
    checks++;
    if ({o_valid, o_busy, o_in_ready} !== 3'b001) begin
      errors++;
      $display("FAIL midrst_after got v=%b b=%b rdy=%b want 0 0 1", o_valid, o_busy, o_in_ready);
    end
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    checks++;
    if ({o_valid, o_index, o_mask, o_last} !== {1'b1, 3'd3, 8'h08, 1'b1}) begin
      errors++;
      $display("FAIL midrst_reload got v=%b i=%0d m=%h l=%b want 1 3 08 1",
               o_valid, o_index, o_mask, o_last);
    end
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    checks++;
    if (o_valid !== 1'b0) begin
      errors++; $display("FAIL midrst_end got v=%b want 0", o_valid);
    end
  endtask

  task automatic test_random();
    int         words;
    int         n;
    logic       iv, ordy, exp_valid, exp_rdy;
    logic [7:0] d;
    int unsigned sel;
    beat_t      h;
    words = 0; n = 0;
    mq.delete();
    while ((words < NW || mq.size() != 0) && n < 90000) begin
      n++;
      iv   = (words < NW) && ($urandom % 4 != 0);
      sel  = $urandom % 8;
      d    = (sel == 0) ? 8'h00 : (sel == 1) ? 8'hFF : 8'($urandom);
      ordy = ($urandom % 4 != 0);
      cyc(1'b0, iv, d, ordy);

      exp_valid = (mq.size() != 0);
      exp_rdy   = 1'b1;
      if (exp_valid) exp_rdy = ordy && mq[0].last;

      checks++;
      if (o_valid !== exp_valid) begin
        errors++; $display("FAIL rand_valid cycle %0d got %b want %b", n, o_valid, exp_valid);
      end
      checks++;
      if (o_in_ready !== exp_rdy) begin
        errors++; $display("FAIL rand_in_ready cycle %0d got %b want %b", n, o_in_ready, exp_rdy);
      end
      if (exp_valid) begin
        h = mq[0];
        checks++;
        if ({o_index, o_mask, o_last, o_zero, o_busy} !== {h.idx, h.mask, h.last, h.zero, 1'b1}) begin
          errors++;
          $display("FAIL rand_beat cycle %0d got i=%0d m=%h l=%b z=%b b=%b want i=%0d m=%h l=%b z=%b b=1",
                   n, o_index, o_mask, o_last, o_zero, o_busy, h.idx, h.mask, h.last, h.zero);
        end
        if (ordy) void'(mq.pop_front());
      end
      if (iv && exp_rdy) begin
        push_word(d);
        words++;
      end
    end
    checks++;
    if (words < NW || mq.size() != 0) begin
      errors++; $display("FAIL rand_timeout got %0d words want %0d", words, NW);
    end
  endtask

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.out_ready = 1'b0;
    test_reset();
    test_pattern();
    test_zero();
    test_full_stall();
    test_back_to_back();
    test_reset_midscan();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
